// File: rtl/display_sequencer.sv
// Seven-segment display sequencer: GAME/HIGHSCORE hold FSM plus iterative binary-to-BCD converter.
// Optional build macro LEADING_BLANK_EN adds registered leading-zero blank flags on blankMask.
module display_sequencer #(
  parameter int HOLD_MS = 3000,
  parameter int CNT_W   = 12
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        oneMsPulse,
  input  logic        showHigh,
  input  logic [23:0] score,
  input  logic [23:0] highscore,
  output logic        dispState,
  output logic [19:0] decDigits,
  output logic        digitsValid,
  output logic        busy,
  output logic [4:0]  blankMask
);

  typedef enum logic {DISP_GAME = 1'b0, DISP_HIGH = 1'b1} disp_t;
  typedef enum logic [1:0] {CV_IDLE = 2'd0, CV_CONV = 2'd1, CV_DONE = 2'd2} conv_t;

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_MS - 1);

  disp_t           r_disp, w_disp_next;
  logic [CNT_W-1:0] r_hold, w_hold_next;

  conv_t           r_cv, w_cv_next;
  logic            r_pending, w_pending_next;
  logic [15:0]     r_last_val, w_last_val_next;
  logic [15:0]     r_temp, w_temp_next;
  logic [4:0][3:0] r_work, w_work_next, w_work_inc;
  logic [2:0]      r_idx, w_idx_next;
  logic [19:0]     r_dec, w_dec_next;
  logic            r_valid, w_valid_next;
  logic            r_busy, w_busy_next;
  logic [15:0]     w_sel, w_pow;
  logic            w_restart;

  genvar gi;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_disp <= DISP_GAME;
      r_hold <= '0;
    end else begin
      r_disp <= w_disp_next;
      r_hold <= w_hold_next;
    end
  end

  // showHigh wins over a coincident ms tick, so the hold always restarts from a fresh request.
  always_comb begin
    w_disp_next = r_disp;
    w_hold_next = r_hold;
    case (r_disp)
      DISP_GAME: begin
        if (showHigh) begin
          w_disp_next = DISP_HIGH;
          w_hold_next = '0;
        end
      end
      DISP_HIGH: begin
        if (showHigh) begin
          w_hold_next = '0;
        end else if (oneMsPulse) begin
          if (r_hold == HOLD_LAST) begin
            w_disp_next = DISP_GAME;
            w_hold_next = '0;
          end else begin
            w_hold_next = r_hold + 1'b1;
          end
        end
      end
      default: begin
        w_disp_next = DISP_GAME;
        w_hold_next = '0;
      end
    endcase
  end

  assign w_sel = (r_disp == DISP_HIGH) ? highscore[15:0] : score[15:0];

  always_comb begin
    case (r_idx)
      3'd4:    w_pow = 16'd10000;
      3'd3:    w_pow = 16'd1000;
      3'd2:    w_pow = 16'd100;
      3'd1:    w_pow = 16'd10;
      default: w_pow = 16'd1;
    endcase
  end

  generate
    for (gi = 0; gi < 5; gi++) begin : g_work_inc
      assign w_work_inc[gi] = (r_idx == 3'(gi)) ? r_work[gi] + 4'd1 : r_work[gi];
    end
  endgenerate

  // Any change of the selected value restarts from scratch, even in the DONE cycle, so stale digits never commit.
  assign w_restart = ((r_cv == CV_IDLE) && r_pending) || (w_sel != r_last_val);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cv       <= CV_IDLE;
      r_pending  <= 1'b1;
      r_last_val <= '0;
      r_temp     <= '0;
      r_work     <= '0;
      r_idx      <= '0;
      r_dec      <= '0;
      r_valid    <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_cv       <= w_cv_next;
      r_pending  <= w_pending_next;
      r_last_val <= w_last_val_next;
      r_temp     <= w_temp_next;
      r_work     <= w_work_next;
      r_idx      <= w_idx_next;
      r_dec      <= w_dec_next;
      r_valid    <= w_valid_next;
      r_busy     <= w_busy_next;
    end
  end

  always_comb begin
    w_cv_next       = r_cv;
    w_pending_next  = r_pending;
    w_last_val_next = r_last_val;
    w_temp_next     = r_temp;
    w_work_next     = r_work;
    w_idx_next      = r_idx;
    w_dec_next      = r_dec;
    w_valid_next    = r_valid;
    w_busy_next     = r_busy;
    if (w_restart) begin
      w_cv_next       = CV_CONV;
      w_pending_next  = 1'b0;
      w_last_val_next = w_sel;
      w_temp_next     = w_sel;
      w_work_next     = '0;
      w_idx_next      = 3'd4;
      w_valid_next    = 1'b0;
      w_busy_next     = 1'b1;
    end else begin
      case (r_cv)
        CV_CONV: begin
          if (r_temp >= w_pow) begin
            w_temp_next = r_temp - w_pow;
            w_work_next = w_work_inc;
          end else if (r_idx != 3'd0) begin
            w_idx_next = r_idx - 3'd1;
          end else begin
            w_cv_next = CV_DONE;
          end
        end
        CV_DONE: begin
          w_dec_next   = r_work;
          w_valid_next = 1'b1;
          w_busy_next  = 1'b0;
          w_cv_next    = CV_IDLE;
        end
        CV_IDLE: ;
        default: w_cv_next = CV_IDLE;
      endcase
    end
  end

  assign dispState   = r_disp;
  assign decDigits   = r_dec;
  assign digitsValid = r_valid;
  assign busy        = r_busy;

`ifdef LEADING_BLANK_EN
  logic [4:0] w_blank;
  logic [4:0] r_blank;

  assign w_blank[0] = 1'b0;
  generate
    for (gi = 1; gi < 5; gi++) begin : g_blank
      assign w_blank[gi] = ~|r_work[4:gi];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      r_blank <= '0;
    end else if ((r_cv == CV_DONE) && !w_restart) begin
      r_blank <= w_blank;
    end
  end

  assign blankMask = r_blank;
`else
  assign blankMask = '0;
`endif

endmodule

// File: tb/tb_display_sequencer.sv
// Scoreboard bench for display_sequencer: randomized display/score traffic against a decimal reference model.
module tb_display_sequencer;

  localparam int HOLD = 5;

  logic        clk = 1'b0;
  logic        reset;
  logic        oneMsPulse;
  logic        showHigh;
  logic [23:0] score;
  logic [23:0] highscore;
  logic        dispState;
  logic [19:0] decDigits;
  logic        digitsValid;
  logic        busy;
  logic [4:0]  blankMask;

  display_sequencer #(.HOLD_MS(HOLD), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .oneMsPulse(oneMsPulse), .showHigh(showHigh),
    .score(score), .highscore(highscore), .dispState(dispState),
    .decDigits(decDigits), .digitsValid(digitsValid), .busy(busy), .blankMask(blankMask)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [19:0] dig;
    logic        disp;
    logic [4:0]  blank;
    int          due;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_bad = 0;
  logic [19:0] committed = '0;
  logic        prev_valid = 1'b0;

  // Reference model state: displayed view and ms pulses seen since the last showHigh.
  logic        m_high = 1'b0;
  int          m_pulses = 0;
  logic [15:0] m_score16 = 16'd0;
  logic [15:0] m_hs16 = 16'd900;

  function automatic logic [19:0] to_bcd(int v);
    logic [19:0] r;
    int t;
    t = v;
    r = '0;
    for (int i = 0; i < 5; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  function automatic int dsum(int v);
    int s;
    s = 0;
    for (int t = v; t > 0; t = t / 10) s += t % 10;
    return s;
  endfunction

  function automatic logic [4:0] blank_of(int v);
    logic [4:0] b;
    b = '0;
`ifdef LEADING_BLANK_EN
    begin
      int nd;
      nd = 1;
      for (int t = v; t >= 10; t = t / 10) nd++;
      for (int i = 1; i < 5; i++) if (i >= nd) b[i] = 1'b1;
    end
`endif
    return b;
  endfunction

  task automatic push(int v, logic d, int start);
    exp_t e;
    e.dig   = to_bcd(v);
    e.disp  = d;
    e.blank = blank_of(v);
    e.due   = start + dsum(v) + 6;
    q.push_back(e);
  endtask

  task automatic chk(string nm, logic [31:0] got, logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h", nm, got, want);
    end
  endtask

  task automatic tick(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (q.size() != 0 && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain_timeout: got %0d outputs outstanding, required 0", q.size());
      q.delete();
    end
    tick(3);
  endtask

  function automatic logic [15:0] fresh16(logic [15:0] avoid);
    logic [15:0] v;
    do begin
      v = ($urandom_range(0, 1) == 1) ? 16'($urandom_range(0, 65535)) : 16'($urandom_range(0, 120));
    end while (v == m_score16 || v == m_hs16 || v == avoid);
    return v;
  endfunction

  task automatic set_score(logic [23:0] s, bit expect_done);
    @(negedge clk);
    if (expect_done) push(int'(s[15:0]), 1'b0, cyc + 1);
    score = s;
    m_score16 = s[15:0];
  endtask

  // One cycle of showHigh/oneMsPulse; the view switches after HOLD pulses with no showHigh in between.
  task automatic step(bit sh, bit pl);
    bit switched;
    @(negedge clk);
    switched = 1'b0;
    if (!m_high) begin
      if (sh) begin
        m_high = 1'b1;
        m_pulses = 0;
        push(int'(m_hs16), 1'b1, cyc + 2);
        switched = 1'b1;
      end
    end else if (sh) begin
      m_pulses = 0;
    end else if (pl) begin
      m_pulses++;
      if (m_pulses == HOLD) begin
        m_high = 1'b0;
        m_pulses = 0;
        push(int'(m_score16), 1'b0, cyc + 2);
        switched = 1'b1;
      end
    end
    showHigh = sh;
    oneMsPulse = pl;
    @(negedge clk);
    showHigh = 1'b0;
    oneMsPulse = 1'b0;
    if (switched) drain();
  endtask

  always @(negedge clk) begin
    if (reset) begin
      prev_valid = 1'b0;
      committed = '0;
    end else begin
      if (digitsValid && !prev_valid) begin
        n_cmp++;
        if (q.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected_done: got digits=%h disp=%0d at cyc %0d, required no output", decDigits, dispState, cyc);
        end else begin
          mon_e = q.pop_front();
          if (decDigits !== mon_e.dig || dispState !== mon_e.disp || blankMask !== mon_e.blank ||
              cyc != mon_e.due || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL done: got digits=%h disp=%0d blank=%b cyc=%0d busy=%0d, required digits=%h disp=%0d blank=%b cyc=%0d busy=0",
                     decDigits, dispState, blankMask, cyc, busy, mon_e.dig, mon_e.disp, mon_e.blank, mon_e.due);
          end else begin
            $display("done ok: digits=%h disp=%0d blank=%b cyc=%0d", decDigits, dispState, blankMask, cyc);
          end
        end
        committed = decDigits;
      end else begin
        n_cmp++;
        if (decDigits !== committed || (busy && digitsValid)) begin
          n_bad++;
          $display("FAIL hold: got digits=%h valid=%0d busy=%0d, required digits=%h and not valid while busy",
                   decDigits, digitsValid, busy, committed);
        end
      end
      prev_valid = digitsValid;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, required finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] a16, b16;
    int k;
    bit sh, pl;
    reset = 1'b1;
    oneMsPulse = 1'b0;
    showHigh = 1'b0;
    score = 24'd0;
    highscore = 24'd900;
    tick(4);
    chk("rst_disp", 32'(dispState), 0);
    chk("rst_digits", 32'(decDigits), 0);
    chk("rst_valid", 32'(digitsValid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_blank", 32'(blankMask), 0);

    @(negedge clk);
    push(0, 1'b0, cyc + 1);
    reset = 1'b0;
    drain();

    set_score(24'd65535, 1'b1);
    drain();

    set_score(24'd1234, 1'b0);
    tick(5);
    set_score(24'd4321, 1'b1);
    drain();

    step(1'b1, 1'b0);
    for (int i = 0; i < HOLD - 1; i++) begin step(1'b0, 1'b1); tick(1); end
    chk("hold_before_exit", 32'(dispState), 1);
    step(1'b0, 1'b1);
    chk("exit_after_hold", 32'(dispState), 0);

    step(1'b1, 1'b0);
    for (int i = 0; i < HOLD - 1; i++) step(1'b0, 1'b1);
    step(1'b1, 1'b1);
    chk("coincident_stay", 32'(dispState), 1);
    for (int i = 0; i < HOLD - 1; i++) step(1'b0, 1'b1);
    chk("coincident_hold", 32'(dispState), 1);
    step(1'b0, 1'b1);
    chk("coincident_exit", 32'(dispState), 0);

    set_score(24'd42, 1'b1);
    drain();
    set_score(24'd0, 1'b1);
    drain();

    for (int it = 0; it < 40; it++) begin
      case ($urandom_range(0, 3))
        0: begin
          a16 = fresh16(16'd0);
          set_score({8'($urandom_range(0, 255)), a16}, !m_high);
          drain();
        end
        1: begin
          score = {8'($urandom_range(0, 255)), m_score16};
          if (!m_high) begin
            m_hs16 = fresh16(16'd0);
            highscore = {8'($urandom_range(0, 255)), m_hs16};
          end else begin
            highscore = {8'($urandom_range(0, 255)), m_hs16};
          end
          tick(40);
        end
        2: begin
          if (!m_high) begin
            a16 = fresh16(16'd0);
            b16 = fresh16(a16);
            k = $urandom_range(1, dsum(int'(a16)) + 6);
            set_score({8'd0, a16}, 1'b0);
            tick(k - 1);
            set_score({8'($urandom_range(0, 255)), b16}, 1'b1);
            drain();
          end
        end
        default: begin
          for (int j = 0; j < 10; j++) begin
            sh = (!m_high && j == 0) || ($urandom_range(0, 5) == 0);
            pl = ($urandom_range(0, 2) != 0);
            step(sh, pl);
            tick($urandom_range(0, 2));
          end
        end
      endcase
    end

    drain();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/display_sequencer.md
Name: display_sequencer

Overview:
Controller that sequences the seven-segment display path of the whack-a-mole game. Owns the GAME/HIGHSCORE display-state machine with its millisecond hold timer. Runs the iterative subtract-by-power-of-ten binary-to-decimal converter for whichever value is selected. Presents stable, registered decimal digits plus the display state to the hex-driver mapping stage.

Parameters:
HOLD_MS, 3000, number of oneMsPulse ticks the high-score view is held before reverting to GAME
CNT_W, 12, hold-counter width; must satisfy 2^CNT_W > HOLD_MS-1

Ports:
clk  input  1  system clock, single clock domain
reset  input  1  synchronous, active-high reset
oneMsPulse  input  1  one-cycle strobe every 1 ms
showHigh  input  1  one-cycle request to show high score (already debounced/edge-detected)
score  input  24  current score; bits [15:0] are converted
highscore  input  24  stored high score; bits [15:0] are converted
dispState  output  1  0 = GAME, 1 = HIGHSCORE
decDigits  output  20  five BCD digits, [19:16] = ten-thousands ... [3:0] = units
digitsValid  output  1  decDigits matches the currently selected value
busy  output  1  converter active
blankMask  output  5  per-digit leading-zero blank flags (see Optional Feature)

Behaviour:
- Reset (sync, clk edge with reset=1): dispState=GAME, hold counter=0, decDigits=0, digitsValid=0, busy=0, blankMask=0, converter IDLE with a pending-start flag set.
- Display FSM, GAME: showHigh=1 -> HIGHSCORE next cycle, counter cleared.
- Display FSM, HIGHSCORE:
  - showHigh=1 clears the counter; it has priority over a coincident oneMsPulse and over timeout.
  - Otherwise each oneMsPulse increments the counter.
  - oneMsPulse while counter==HOLD_MS-1 -> GAME, counter=0.
  - Net effect: exactly HOLD_MS pulses after the last showHigh.
- Selected value sel = score[15:0] in GAME, highscore[15:0] in HIGHSCORE.
- Converter states:
  - IDLE: starts when the pending flag is set or sel != lastVal. START: lastVal<=sel, temp<=sel, working digits<=0, idx<=4, busy=1, digitsValid=0.
  - CONV, one action per cycle: temp>=10^idx -> temp-=10^idx, work[idx]+=1. Otherwise, if idx>0 then idx-=1; if idx==0 then go to DONE.
  - DONE (one cycle): decDigits<=work, digitsValid=1, busy=0, return to IDLE.
- Latency from START to digitsValid high = 1 + sum(digits) + 5 + 1 cycles. Example: 0 -> 7 cycles; 65535 -> 31 cycles.
- decDigits only updates in DONE. Outputs never show partial conversions; the old digits stay on display while busy.
- sel changes mid-conversion (score update or display-state change): abandon and re-enter START next cycle. No DONE is emitted for the stale value.
- reset asserted mid-conversion: everything returns to reset values, and conversion restarts the cycle after reset deasserts.
- Arithmetic: temp is 16 bits, powers are 16-bit constants 10000/1000/100/10/1, and digit counters are 4 bits (max 9 by construction). Bits [23:16] of score/highscore are ignored by the converter.

Optional Feature:
LEADING_BLANK_EN
- Defined: in DONE, blankMask[i]=1 for each digit i>=1 that is zero and has all higher digits zero. blankMask[0] is always 0. blankMask is registered alongside decDigits.
- Undefined: blankMask is constant 0 and no blank logic is synthesized.

Test Plan:
- Reset, then hold score=16'd0 -> 7 cycles after reset release: digitsValid=1, decDigits=20'h00000, dispState=0.
- score=16'd65535 steady -> after 31 cycles decDigits=20'h65535, digitsValid=1. busy is high for those cycles and decDigits is unchanged until DONE.
- score changes 1234 -> 4321 while busy -> no DONE for 1234; final decDigits=20'h04321.
- showHigh pulse with highscore=16'd900 and HOLD_MS=5 (sim override) -> dispState=1 and decDigits=20'h00900. Exactly 5 oneMsPulse later dispState=0, then decDigits returns to the score digits.
- In HIGHSCORE, showHigh coincident with the 5th oneMsPulse -> stays HIGHSCORE, counter=0, needs 5 more pulses to exit.
- With LEADING_BLANK_EN and score=42 -> blankMask=5'b11100; score=0 -> 5'b11110. Without the macro, blankMask=0 in both cases.
